// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte path.
//   UART_DATA_W : width of one UART character
//   tx_state_e  : transmit sequencer state encoding (IDLE=0 .. GAP=4)
//   max_int     : elaboration-time helper for sizing counters
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    BUSY = 3'd3,
    GAP  = 3'd4
  } tx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO, no fall-through (data pushed this cycle is
// poppable from the next cycle on). Shared by the transmit and receive paths.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push/din : write request and data; ignored while full
//   pop/dout : read request; dout always shows the head entry
//   full, empty, count : occupancy flags and entry count 0..DEPTH
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push while full is refused even if a pop frees a slot the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and sequencer in front of the UART transmitter. Bytes are
// buffered in a FIFO and handed to the transmitter one at a time through a
// level-sensitive enable/data pair, paced by the transmitter's busy flag.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   wr_en, wr_data   : push request/byte, accepted when wr_ready
//   wr_ready         : FIFO not full
//   fifo_level       : entries queued, 0..DEPTH
//   tx_flag          : transmitter busy, high for one frame
//   uart_en          : transmit enable; rising edge starts a frame
//   uart_din         : byte to transmit, stable while uart_en is high
//   idle             : FIFO empty and sequencer idle
//   timeout_err      : sticky, tx_flag failed to rise within BUSY_TIMEOUT
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   wr_ready,
  output logic [ADDR_W:0]        fifo_level,
  input  logic                   tx_flag,
  output logic                   uart_en,
  output logic [UART_DATA_W-1:0] uart_din,
  output logic                   idle,
  output logic                   timeout_err
);

  localparam int TMR_MAX = max_int(BUSY_TIMEOUT, GAP_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // The timer counts edges already spent in a state, so the last permitted
  // edge is reached at value N-1.
  localparam logic [TMR_W-1:0] ARM_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  tx_state_e              state;
  tx_state_e              state_n;
  logic [TMR_W-1:0]       timer;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   en_set;
  logic                   en_clr;
  logic                   tmr_clr;
  logic                   tmr_inc;
  logic                   err_set;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level)
  );

  assign wr_ready = !fifo_full;
  assign idle     = fifo_empty && (state == IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    en_set   = 1'b0;
    en_clr   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        en_set  = 1'b1;
        tmr_clr = 1'b1;
        state_n = ARM;
      end
      ARM: begin
        // The busy flag wins over a timeout landing on the same edge.
        if (tx_flag) begin
          state_n = BUSY;
        end else if (timer == ARM_LAST) begin
          err_set = 1'b1;
          en_clr  = 1'b1;
          tmr_clr = 1'b1;
          state_n = GAP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      BUSY: begin
        if (!tx_flag) begin
          en_clr  = 1'b1;
          tmr_clr = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        // Low time guarantees the transmitter's edge detector sees a 0.
        if (timer == GAP_LAST) state_n = IDLE;
        else                   tmr_inc = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      uart_en     <= 1'b0;
      uart_din    <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (fifo_pop)     uart_din <= fifo_dout;
      if (en_set)       uart_en  <= 1'b1;
      else if (en_clr)  uart_en  <= 1'b0;
      if (tmr_clr)      timer    <= '0;
      else if (tmr_inc) timer    <= timer + 1'b1;
      if (err_set)      timeout_err <= 1'b1;
    end
  end

endmodule
